// File: rtl/bc_bus_pkg.sv
// Shared definitions for the Basic Computer common bus: mux select codes
// and the arbiter state encoding.
package bc_bus_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
    localparam logic [SEL_W-1:0] SEL_AR   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_PC   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_DR   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_AC   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_IR   = 3'd5;
    localparam logic [SEL_W-1:0] SEL_TR   = 3'd6;
    localparam logic [SEL_W-1:0] SEL_MEM  = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arbState_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the control sequencer (master) and the
// bus arbiter (slave).
interface bus_arbiter_if
    import bc_bus_pkg::*;
#(
    parameter int NREQ  = 7,
    parameter int SEL_W = bc_bus_pkg::SEL_W
);

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  done;
    logic [NREQ-1:0]  gnt;
    logic [SEL_W-1:0] bus_sel;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  bus_sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output bus_sel,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first unmasked request at or after i_start,
// wrapping modulo NREQ.
module rr_pick
    import bc_bus_pkg::*;
#(
    parameter int NREQ  = 7,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_start,
    input  logic [NREQ-1:0]  i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [NREQ-1:0] w_cand;

    assign w_cand = i_req & ~i_mask;

    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] start, input int offset);
        return IDX_W'((int'(start) + offset) % NREQ);
    endfunction

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_cand[wrapIdx(i_start, k)]) begin
                o_idx   = wrapIdx(i_start, k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the common bus: grants one requester at a time,
// holds it until done, withdrawal or tenure limit, and drives the mux select.
module bus_arbiter
    import bc_bus_pkg::*;
#(
    parameter int NREQ     = 7,
    parameter int SEL_W    = bc_bus_pkg::SEL_W,
    parameter int MAX_HOLD = 4
) (
    input logic           clk,
    input logic           rst,
    bus_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TEN_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [TEN_W-1:0] TEN_LIMIT = TEN_W'(MAX_HOLD - 1);

    arbState_t        r_state;
    arbState_t        w_nextState;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [NREQ-1:0]  r_gnt;
    logic [SEL_W-1:0] r_busSel;
    logic             r_timeout;
    logic [TEN_W-1:0] r_tenure;

    logic [IDX_W-1:0] w_start;
    logic [NREQ-1:0]  w_mask;
    logic [IDX_W-1:0] w_pickIdx;
    logic             w_pickValid;
    logic             w_ownerDone;
    logic             w_ownerReq;
    logic             w_limit;
    logic             w_release;
    logic             w_grant;
    logic [IDX_W-1:0] w_nextOwner;
    logic [NREQ-1:0]  w_nextGnt;
    logic [SEL_W-1:0] w_nextBusSel;
    logic             w_nextTimeout;
    logic [TEN_W-1:0] w_nextTenure;

    assign w_start     = (r_last == LAST_IDX) ? '0 : r_last + IDX_W'(1);
    assign w_mask      = (r_state == OWN) ? (NREQ'(1) << r_owner) : '0;
    assign w_ownerDone = bus.done[r_owner];
    assign w_ownerReq  = bus.req[r_owner];
    assign w_limit     = (MAX_HOLD != 0) && (r_tenure == TEN_LIMIT);

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (bus.req),
        .i_start (w_start),
        .i_mask  (w_mask),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_last    <= LAST_IDX;
            r_gnt     <= '0;
            r_busSel  <= SEL_W'(SEL_NONE);
            r_timeout <= 1'b0;
            r_tenure  <= '0;
        end else begin
            r_state   <= w_nextState;
            r_owner   <= w_nextOwner;
            r_gnt     <= w_nextGnt;
            r_busSel  <= w_nextBusSel;
            r_timeout <= w_nextTimeout;
            r_tenure  <= w_nextTenure;
            if (w_grant) begin
                r_last <= w_nextOwner;
            end
        end
    end

    // A timed-out owner that is still requesting only gets the bus back
    // when nobody else is waiting.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pickValid) begin
                    w_nextState = OWN;
                    w_nextOwner = w_pickIdx;
                    w_grant     = 1'b1;
                end
            end
            OWN: begin
                w_release = w_ownerDone || !w_ownerReq || w_limit;
                if (w_release) begin
                    if (w_pickValid) begin
                        w_nextOwner = w_pickIdx;
                        w_grant     = 1'b1;
                    end else if (w_limit && !w_ownerDone && w_ownerReq) begin
                        w_grant = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_nextGnt     = '0;
        w_nextBusSel  = SEL_W'(SEL_NONE);
        w_nextTimeout = (r_state == OWN) && w_limit && !w_ownerDone;
        w_nextTenure  = r_tenure;
        if (w_nextState == OWN) begin
            w_nextGnt    = NREQ'(1) << w_nextOwner;
            w_nextBusSel = SEL_W'(w_nextOwner) + SEL_W'(1);
        end
        if (w_grant || w_nextState == IDLE) begin
            w_nextTenure = '0;
        end else if (r_tenure != '1) begin
            w_nextTenure = r_tenure + TEN_W'(1);
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.bus_sel = r_busSel;
    assign bus.busy    = |r_gnt;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter against a behavioural
// owner/pointer/tenure model.
module tb_bus_arbiter;

    localparam int NREQ     = 7;
    localparam int SEL_W    = 3;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    bus_arbiter_if #(.NREQ(NREQ), .SEL_W(SEL_W)) busIf ();

    bus_arbiter #(
        .NREQ     (NREQ),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    int checks   = 0;
    int failures = 0;

    int mOwner;
    int mLast;
    int mTenure;
    bit mTimeout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelPick(input logic [NREQ-1:0] r, input int last, input int excl);
        for (int off = 1; off <= NREQ; off++) begin
            int c;
            c = (last + off) % NREQ;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner   = -1;
        mLast    = NREQ - 1;
        mTenure  = 0;
        mTimeout = 1'b0;
    endtask

    task automatic modelGrant(input int who);
        mOwner  = who;
        mLast   = who;
        mTenure = 0;
    endtask

    task automatic modelStep(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        int w;
        bit ownDone;
        bit ownReq;
        bit atLimit;
        mTimeout = 1'b0;
        if (mOwner < 0) begin
            w = modelPick(r, mLast, -1);
            if (w >= 0) modelGrant(w);
        end else begin
            ownDone = d[mOwner];
            ownReq  = r[mOwner];
            atLimit = (MAX_HOLD != 0) && (mTenure == MAX_HOLD - 1);
            if (ownDone || !ownReq || atLimit) begin
                if (atLimit && !ownDone) mTimeout = 1'b1;
                w = modelPick(r, mLast, mOwner);
                if (w >= 0) modelGrant(w);
                else if (atLimit && !ownDone && ownReq) modelGrant(mOwner);
                else begin
                    mOwner  = -1;
                    mTenure = 0;
                end
            end else begin
                mTenure++;
            end
        end
    endtask

    task automatic compareModel(input string tag);
        logic [31:0] expGnt;
        expGnt = (mOwner < 0) ? 32'd0 : (32'd1 << mOwner);
        checkOutput({tag, ".gnt"}, 32'(busIf.gnt), expGnt);
        checkOutput({tag, ".bus_sel"}, 32'(busIf.bus_sel), 32'(mOwner + 1));
        checkOutput({tag, ".busy"}, 32'(busIf.busy), 32'(mOwner >= 0));
        checkOutput({tag, ".timeout"}, 32'(busIf.timeout), 32'(mTimeout));
    endtask

    task automatic applyStimulus(input string tag, input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        busIf.req  = r;
        busIf.done = d;
        @(posedge clk);
        modelStep(r, d);
        @(negedge clk);
        busIf.done = '0;
        compareModel(tag);
    endtask

    task automatic applyReset(input logic [NREQ-1:0] r);
        busIf.req  = r;
        busIf.done = '0;
        rst = 1'b1;
        #1;
        modelReset();
        compareModel("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] d;

        rst        = 1'b1;
        busIf.req  = '1;
        busIf.done = '0;
        modelReset();
        #1;
        compareModel("por");
        checkOutput("porSel", 32'(busIf.bus_sel), 32'd0);
        applyReset(7'b1111111);
        applyStimulus("rstRel", 7'b1111111, '0);
        checkOutput("rstRelSel", 32'(busIf.bus_sel), 32'd1);

        applyReset('0);
        applyStimulus("single", 7'b0001000, '0);
        checkOutput("singleSel", 32'(busIf.bus_sel), 32'd4);
        applyStimulus("single", 7'b0001000, '0);
        applyStimulus("single", 7'b0001000, 7'b0001000);
        checkOutput("singleIdle", 32'(busIf.busy), 32'd0);
        applyStimulus("single", 7'b0000000, '0);

        applyStimulus("contend", 7'b0000110, '0);
        for (int i = 0; i < 6; i++) begin
            d = busIf.gnt;
            applyStimulus("contend", 7'b0000110, d);
            checkOutput("contendBusy", 32'(busIf.busy), 32'd1);
        end
        applyStimulus("contend", 7'b0000000, '0);

        applyReset('0);
        applyStimulus("tmo", 7'b1000000, '0);
        for (int i = 0; i < 4; i++) applyStimulus("tmo", 7'b1000001, '0);
        checkOutput("tmoSel", 32'(busIf.bus_sel), 32'd1);
        checkOutput("tmoPulse", 32'(busIf.timeout), 32'd1);
        applyStimulus("tmo", 7'b0000000, '0);
        for (int i = 0; i < 10; i++) applyStimulus("tmoAlone", 7'b1000000, '0);
        applyStimulus("tmoAlone", 7'b0000000, '0);

        applyReset('0);
        applyStimulus("bound", 7'b0100000, '0);
        applyStimulus("bound", 7'b0100000, 7'b0000100);
        checkOutput("boundIgnore", 32'(busIf.bus_sel), 32'd6);
        applyStimulus("bound", 7'b0100000, '0);
        applyStimulus("bound", 7'b0100000, '0);
        applyStimulus("bound", 7'b0100000, 7'b0100000);
        checkOutput("boundDoneTmo", 32'(busIf.timeout), 32'd0);
        checkOutput("boundDoneSel", 32'(busIf.bus_sel), 32'd0);
        applyStimulus("bound", 7'b0000000, 7'b0010000);

        applyStimulus("midRst", 7'b0100000, '0);
        applyStimulus("midRst", 7'b0100000, '0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        compareModel("asyncRst");
        checkOutput("asyncRstSel", 32'(busIf.bus_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("midRst", 7'b0100001, '0);
        checkOutput("midRstFirst", 32'(busIf.bus_sel), 32'd1);

        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 7'($urandom) & 7'($urandom);
            d = ($urandom_range(0, 2) == 0) ? 7'($urandom) : '0;
            if ($urandom_range(0, 149) == 0) applyReset(r);
            else applyStimulus("rand", r, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
